id_fwd_scoreboard: RTL

ID_FWD_SCOREBOARD -- requirements
Module: id_fwd_scoreboard

---
 rtl/id_fwd_scoreboard_if.sv | 58 +++++
 rtl/id_fwd_scoreboard.sv | 104 ++++++++++
 2 files changed

// File: rtl/id_fwd_scoreboard_if.sv
// Operand-read, pipeline-writeback and long-latency bookkeeping bus between the
// ID stage (master) and the forwarding/scoreboard unit (slave).
interface id_fwd_scoreboard_if #(
    parameter int unsigned NUM_RP = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic [NUM_RP-1:0]        rden_i;
    logic [5*NUM_RP-1:0]      raddr_i;
    logic [DATA_W*NUM_RP-1:0] rf_rdata_i;

    logic                     ex_we_i;
    logic [4:0]               ex_waddr_i;
    logic [DATA_W-1:0]        ex_wdata_i;
    logic                     ex_vld_i;

    logic                     mem_we_i;
    logic [4:0]               mem_waddr_i;
    logic [DATA_W-1:0]        mem_wdata_i;
    logic                     mem_vld_i;

    logic                     wb_we_i;
    logic [4:0]               wb_waddr_i;
    logic [DATA_W-1:0]        wb_wdata_i;

    logic                     lng_issue_i;
    logic [4:0]               lng_waddr_i;
    logic                     lng_done_i;
    logic [4:0]               lng_done_waddr_i;
    logic                     flush_i;
    logic                     cnt_clr_i;

    logic [DATA_W*NUM_RP-1:0] rdata_o;
    logic                     stall_req_o;
    logic                     sb_busy_o;
    logic                     sb_ovf_o;
    logic [CNT_W-1:0]         stall_cnt_o;

    modport master (
        output rden_i, raddr_i, rf_rdata_i,
        output ex_we_i, ex_waddr_i, ex_wdata_i, ex_vld_i,
        output mem_we_i, mem_waddr_i, mem_wdata_i, mem_vld_i,
        output wb_we_i, wb_waddr_i, wb_wdata_i,
        output lng_issue_i, lng_waddr_i, lng_done_i, lng_done_waddr_i,
        output flush_i, cnt_clr_i,
        input  rdata_o, stall_req_o, sb_busy_o, sb_ovf_o, stall_cnt_o
    );

    modport slave (
        input  rden_i, raddr_i, rf_rdata_i,
        input  ex_we_i, ex_waddr_i, ex_wdata_i, ex_vld_i,
        input  mem_we_i, mem_waddr_i, mem_wdata_i, mem_vld_i,
        input  wb_we_i, wb_waddr_i, wb_wdata_i,
        input  lng_issue_i, lng_waddr_i, lng_done_i, lng_done_waddr_i,
        input  flush_i, cnt_clr_i,
        output rdata_o, stall_req_o, sb_busy_o, sb_ovf_o, stall_cnt_o
    );
endinterface

// File: rtl/id_fwd_scoreboard.sv
// ID-stage operand forwarding (EX > MEM > WB > RF) with a per-register
// pending-count scoreboard for long-latency ops and a saturating stall counter.
module id_fwd_scoreboard #(
    parameter int unsigned NUM_RP = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PEND_W = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    id_fwd_scoreboard_if.slave   bus
);
    localparam int unsigned NREG = 32;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0]        r_pend [NREG];
    logic                     r_ovf;
    logic [CNT_W-1:0]         r_stall_cnt;

    logic [NUM_RP-1:0]        w_haz;
    logic [DATA_W*NUM_RP-1:0] w_rdata;
    logic                     w_stall;
    logic                     w_issue;
    logic                     w_done;
    logic [NREG-1:0]          w_inc;
    logic [NREG-1:0]          w_dec;
    logic                     w_busy;

    for (genvar p = 0; p < NUM_RP; p++) begin : g_port
        logic [4:0]        w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_fwd_haz;
        logic              w_done_byp;
        logic              w_pend_haz;

        assign w_addr = bus.raddr_i[5*p +: 5];

        // Op retiring this cycle with its last pending instance: take WB data, no stall.
        assign w_done_byp = bus.lng_done_i && (bus.lng_done_waddr_i == w_addr) &&
                            (r_pend[w_addr] == PEND_W'(1));
        assign w_pend_haz = (r_pend[w_addr] != '0) && !w_done_byp;

        // First matching in-flight stage wins; an unproduced result there stalls.
        always_comb begin
            w_data    = bus.rf_rdata_i[DATA_W*p +: DATA_W];
            w_fwd_haz = 1'b0;
            if (w_addr != 5'd0) begin
                if (bus.ex_we_i && bus.ex_waddr_i == w_addr) begin
                    w_data    = bus.ex_wdata_i;
                    w_fwd_haz = !bus.ex_vld_i;
                end else if (bus.mem_we_i && bus.mem_waddr_i == w_addr) begin
                    w_data    = bus.mem_wdata_i;
                    w_fwd_haz = !bus.mem_vld_i;
                end else if (w_done_byp || (bus.wb_we_i && bus.wb_waddr_i == w_addr)) begin
                    w_data    = bus.wb_wdata_i;
                end
            end
        end

        assign w_haz[p] = bus.rden_i[p] && (w_fwd_haz || w_pend_haz);
        assign w_rdata[DATA_W*p +: DATA_W] = rst_i ? '0 : w_data;
    end

    assign w_stall = !rst_i && (|w_haz);
    assign w_issue = bus.lng_issue_i && !bus.flush_i && !w_stall && (bus.lng_waddr_i != 5'd0);
    assign w_done  = bus.lng_done_i && (bus.lng_done_waddr_i != 5'd0);
    assign w_inc   = w_issue ? (NREG'(1) << bus.lng_waddr_i) : '0;
    assign w_dec   = w_done ? (NREG'(1) << bus.lng_done_waddr_i) : '0;

    // Pending counters saturate at both ends; any saturation is a sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
            r_ovf <= 1'b0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    if (r_pend[i] == PEND_MAX) r_ovf <= 1'b1;
                    else                       r_pend[i] <= r_pend[i] + PEND_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    if (r_pend[i] == '0) r_ovf <= 1'b1;
                    else                 r_pend[i] <= r_pend[i] - PEND_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                      r_stall_cnt <= '0;
        else if (bus.cnt_clr_i)         r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NREG; i++) w_busy = w_busy | (r_pend[i] != '0);
    end

    assign bus.rdata_o     = w_rdata;
    assign bus.stall_req_o = w_stall;
    assign bus.sb_busy_o   = w_busy;
    assign bus.sb_ovf_o    = r_ovf;
    assign bus.stall_cnt_o = r_stall_cnt;
endmodule
